lfu_repl_n: RTL and testbench
=============================

LFU_REPL_N -- requirements
Module: lfu_repl_n

Interface
REQ-001 Parameter NUM_BUF, default 4, number of buffers tracked; power of two, 2..64.
REQ-002 Parameter CNT_W, default 4, width of each per-buffer access counter; 2..8.
REQ-003 Localparam IDX_W = clog2(NUM_BUF), buffer index width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 ref_valid  input  1  a buffer reference occurs this cycle.
REQ-007 ref_buf_numbr  input  IDX_W  index of the referenced buffer; sampled only when ref_valid=1.
REQ-008 new_buf_req  input  1  request to choose a replacement victim.
REQ-009 busy  output  1  victim search in progress; high whenever state is not IDLE.
REQ-010 buf_num_replc  output  IDX_W  registered victim index; holds its value between searches.
REQ-011 replc_valid  output  1  one-cycle pulse marking buf_num_replc as newly valid.

Function
REQ-012 The block SHALL keep one CNT_W-bit counter cnt[i] per buffer.
REQ-013 On ref_valid=1, cnt[ref_buf_numbr] SHALL increment by 1; at all-ones it SHALL saturate unless aging is compiled in (REQ-024).
REQ-014 FSM states SHALL be IDLE, SCAN and DONE; busy = (state != IDLE).
REQ-015 IDLE with new_buf_req=1 SHALL accept the request: best_idx<=0, best_cnt<=cnt[0], scan_idx<=1, state<=SCAN.
REQ-016 new_buf_req in SCAN or DONE SHALL be ignored, not queued.
REQ-017 Each SCAN cycle SHALL compare live cnt[scan_idx] against best_cnt and update best_idx/best_cnt only on strict less-than, so ties resolve to the lowest index.
REQ-018 SCAN SHALL go to DONE on the cycle it compares index NUM_BUF-1; otherwise scan_idx increments.
REQ-019 DONE SHALL register buf_num_replc<=best_idx, pulse replc_valid=1 for exactly one cycle, clear cnt[best_idx] to 0, and return to IDLE.
REQ-020 Latency: replc_valid SHALL go high at the NUM_BUF-th rising edge after the accepting edge; the next request SHALL be acceptable one edge later.
REQ-021 References SHALL be applied in every state, including during SCAN and DONE.
REQ-022 In DONE, a simultaneous ref_valid to best_idx SHALL be overridden by the clear: the counter ends at 0.

Reset
REQ-023 rst=1 SHALL force all cnt[i]=0, state=IDLE, busy=0, buf_num_replc=0, replc_valid=0, best/scan registers=0. The reset takes effect at any point, including mid-SCAN or in DONE; an aborted search SHALL produce no replc_valid pulse.

Configuration
REQ-024 Macro LFU_AGING_EN: when defined, an increment that would overflow a saturated counter SHALL instead right-shift every counter by 1 in that cycle; the referenced counter SHALL become (2^CNT_W-1 >> 1)+1, and during SCAN best_cnt SHALL also be right-shifted. When not defined, counters saturate at 2^CNT_W-1 and no aging logic exists.

Verification
REQ-025 The bench SHALL cover the following directed scenarios (NUM_BUF=4, CNT_W=4):
- Reset then new_buf_req -> busy for 4 cycles, replc_valid pulse with buf_num_replc=0, cnt[0]=0.
- Refs 0,0,1,2 then request -> buf_num_replc=3.
- Refs 0,1 then request -> buf_num_replc=2 (tie between 2 and 3 resolves to the lowest index); a second request with no further refs -> 2 again (cnt[2] cleared).
- 16 refs to buffer 1 with refs 0,2,3 each twice -> without macro cnt[1]=15 and others=2; with LFU_AGING_EN cnt[1]=8 and others=1.
- Request while busy -> ignored, exactly one replc_valid; ref to the victim on the DONE cycle -> victim counter=0.
- rst pulse during SCAN -> busy=0 next cycle, no replc_valid, all counters 0.

Source files
------------

// File: rtl/lfu_repl_n.sv
// lfu_repl_n: least-frequently-used replacement victim selector.
// Keeps a saturating access counter per buffer and, on request, scans all
// counters one per cycle to pick the lowest count (ties go to the lowest
// index), then clears the chosen buffer's counter.
// Optional feature: define LFU_AGING_EN to halve all counters instead of
// saturating when a referenced counter is already at its maximum.
module lfu_repl_n #(
    parameter int NUM_BUF = 4,
    parameter int CNT_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ref_valid,
    input  logic [$clog2(NUM_BUF)-1:0] ref_buf_numbr,
    input  logic                       new_buf_req,
    output logic                       busy,
    output logic [$clog2(NUM_BUF)-1:0] buf_num_replc,
    output logic                       replc_valid
);

    localparam int IDX_W = $clog2(NUM_BUF);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BUF - 1);
`ifdef LFU_AGING_EN
    localparam logic [CNT_W-1:0] AGED_REF = (CNT_MAX >> 1) + 1'b1;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt [NUM_BUF];
    logic [IDX_W-1:0] best_idx;
    logic [IDX_W-1:0] scan_idx;
    logic [CNT_W-1:0] best_cnt;
    logic             ref_sat;
    logic             scan_less;
    logic [CNT_W-1:0] scan_pick;

    // A reference hitting a counter that is already at its maximum.
    assign ref_sat   = ref_valid && (cnt[ref_buf_numbr] == CNT_MAX);
    assign scan_less = cnt[scan_idx] < best_cnt;
    assign scan_pick = scan_less ? cnt[scan_idx] : best_cnt;
    assign busy      = (state_q != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: accept in IDLE, walk every index in SCAN, one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (new_buf_req) state_d = SCAN;
            SCAN:    if (scan_idx == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Running minimum search; strict less-than keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_idx <= '0;
            best_cnt <= '0;
            scan_idx <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (new_buf_req) begin
                        best_idx <= '0;
                        best_cnt <= cnt[0];
                        scan_idx <= IDX_W'(1);
                    end
                end
                SCAN: begin
                    if (scan_less) best_idx <= scan_idx;
`ifdef LFU_AGING_EN
                    best_cnt <= ref_sat ? (scan_pick >> 1) : scan_pick;
`else
                    best_cnt <= scan_pick;
`endif
                    if (scan_idx != LAST_IDX) scan_idx <= scan_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Publish the victim and pulse valid for the single DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_num_replc <= '0;
            replc_valid   <= 1'b0;
        end else begin
            replc_valid <= (state_q == DONE);
            if (state_q == DONE) buf_num_replc <= best_idx;
        end
    end

    // Access counters; the victim clear is last so it beats a same-cycle reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BUF; i++) cnt[i] <= '0;
        end else begin
            if (ref_valid) begin
`ifdef LFU_AGING_EN
                if (ref_sat) begin
                    for (int i = 0; i < NUM_BUF; i++) cnt[i] <= cnt[i] >> 1;
                    cnt[ref_buf_numbr] <= AGED_REF;
                end else begin
                    cnt[ref_buf_numbr] <= cnt[ref_buf_numbr] + 1'b1;
                end
`else
                if (!ref_sat) cnt[ref_buf_numbr] <= cnt[ref_buf_numbr] + 1'b1;
`endif
            end
            if (state_q == DONE) cnt[best_idx] <= '0;
        end
    end

endmodule

// File: tb/tb_lfu_repl_n.sv
// tb_lfu_repl_n: self-checking bench for lfu_repl_n (NUM_BUF=4, CNT_W=4).
// Works with or without LFU_AGING_EN defined; expectations follow the macro.
module tb_lfu_repl_n;

    localparam int NB   = 4;
    localparam int CMAX = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       ref_valid;
    logic [1:0] ref_buf_numbr;
    logic       new_buf_req;
    logic       busy;
    logic [1:0] buf_num_replc;
    logic       replc_valid;

    lfu_repl_n #(.NUM_BUF(NB), .CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .ref_valid     (ref_valid),
        .ref_buf_numbr (ref_buf_numbr),
        .new_buf_req   (new_buf_req),
        .busy          (busy),
        .buf_num_replc (buf_num_replc),
        .replc_valid   (replc_valid)
    );

    always #5 clk = ~clk;

    int vec_count   = 0;
    int miscompares = 0;

    // Reference model: counter values, the value each index showed when the
    // search looked at it, and how many cycles the current search has run.
    int cnt_m [NB];
    int seen  [NB];
    int phase    = 0;
    int m_victim = 0;
    bit m_valid  = 1'b0;

    typedef struct {
        bit r;
        bit rv;
        int rb;
        bit rq;
        bit eb;
        bit ev;
        int evict;
    } vec_t;

    vec_t tbl [$];

    task automatic modelStep(input bit r, input bit rv, input int rb, input bit rq);
        int  victim;
        bit  done;
        if (r) begin
            foreach (cnt_m[i]) cnt_m[i] = 0;
            phase    = 0;
            m_victim = 0;
            m_valid  = 1'b0;
            return;
        end
        done   = (phase == NB);
        victim = 0;
        if (done) begin
            for (int i = 1; i < NB; i++) if (seen[i] < seen[victim]) victim = i;
        end
        if (phase == 0 && rq) seen[0] = cnt_m[0];
        else if (phase >= 1 && phase < NB) seen[phase] = cnt_m[phase];
        if (rv) begin
            if (cnt_m[rb] < CMAX) begin
                cnt_m[rb] = cnt_m[rb] + 1;
            end else begin
`ifdef LFU_AGING_EN
                foreach (cnt_m[i]) cnt_m[i] = cnt_m[i] / 2;
                cnt_m[rb] = CMAX / 2 + 1;
`endif
            end
        end
        m_valid = done;
        if (done) begin
            cnt_m[victim] = 0;
            m_victim      = victim;
            phase         = 0;
        end else if (phase == 0) begin
            phase = rq ? 1 : 0;
        end else begin
            phase = phase + 1;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit rv, input int rb, input bit rq);
        rst           = r;
        ref_valid     = rv;
        ref_buf_numbr = 2'(rb);
        new_buf_req   = rq;
        @(posedge clk);
        modelStep(r, rv, rb, rq);
        #1;
    endtask

    task automatic checkOutput(input string name, input bit eb, input bit ev, input int evict);
        vec_count++;
        if (busy !== eb || replc_valid !== ev || buf_num_replc !== 2'(evict)) begin
            miscompares++;
            $display("[TB] FAIL %s: got busy=%0b valid=%0b victim=%0d, want busy=%0b valid=%0b victim=%0d",
                     name, busy, replc_valid, buf_num_replc, eb, ev, evict);
        end
    endtask

    // Issue a request and wait a bounded number of cycles for the victim.
    task automatic runRequest(input string name, input int exp_victim);
        bit got;
        got = 1'b0;
        applyStimulus(0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 0, 0, 0);
            if (replc_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        vec_count++;
        if (!got || buf_num_replc !== 2'(exp_victim)) begin
            miscompares++;
            $display("[TB] FAIL %s: got valid_seen=%0b victim=%0d, want victim=%0d",
                     name, got, buf_num_replc, exp_victim);
        end
        applyStimulus(0, 0, 0, 0);
    endtask

    task automatic refs(input int b, input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 1, b, 0);
    endtask

    initial begin
        bit r;
        bit rv;
        int rb;
        bit rq;
        int valid_seen;

        rst = 1'b1; ref_valid = 1'b0; ref_buf_numbr = '0; new_buf_req = 1'b0;

        // Reset, request on empty counters, refs 0,0,1,2, tie case twice.
        tbl.push_back('{1,0,0,0, 0,0,0});
        tbl.push_back('{0,0,0,1, 1,0,0});
        repeat (3) tbl.push_back('{0,0,0,0, 1,0,0});
        tbl.push_back('{0,0,0,0, 0,1,0});
        tbl.push_back('{0,0,0,0, 0,0,0});
        tbl.push_back('{0,1,0,0, 0,0,0});
        tbl.push_back('{0,1,0,0, 0,0,0});
        tbl.push_back('{0,1,1,0, 0,0,0});
        tbl.push_back('{0,1,2,0, 0,0,0});
        tbl.push_back('{0,0,0,1, 1,0,0});
        repeat (3) tbl.push_back('{0,0,0,0, 1,0,0});
        tbl.push_back('{0,0,0,0, 0,1,3});
        tbl.push_back('{0,0,0,0, 0,0,3});
        tbl.push_back('{1,0,0,0, 0,0,0});
        tbl.push_back('{0,1,0,0, 0,0,0});
        tbl.push_back('{0,1,1,0, 0,0,0});
        tbl.push_back('{0,0,0,1, 1,0,0});
        repeat (3) tbl.push_back('{0,0,0,0, 1,0,0});
        tbl.push_back('{0,0,0,0, 0,1,2});
        tbl.push_back('{0,0,0,1, 1,0,2});
        repeat (3) tbl.push_back('{0,0,0,0, 1,0,2});
        tbl.push_back('{0,0,0,0, 0,1,2});
        tbl.push_back('{0,0,0,0, 0,0,2});

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].r, tbl[i].rv, tbl[i].rb, tbl[i].rq);
            checkOutput($sformatf("table[%0d]", i), tbl[i].eb, tbl[i].ev, tbl[i].evict);
        end

        // Saturation versus aging, probed through which buffer becomes victim.
        applyStimulus(1, 0, 0, 0);
        refs(0, 2); refs(2, 2); refs(3, 2);
        refs(1, 16);
        refs(0, 9); refs(2, 9); refs(3, 9);
`ifdef LFU_AGING_EN
        runRequest("aging victim", 1);
`else
        runRequest("saturate victim", 0);
`endif

        // Requests while busy are dropped; a ref to the victim in DONE loses to the clear.
        applyStimulus(1, 0, 0, 0);
        refs(0, 1); refs(1, 1); refs(2, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("busy accept", 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 1);
            checkOutput("busy ignore req", 1, 0, 0);
        end
        applyStimulus(0, 1, 3, 1);
        checkOutput("done with ref", 0, 1, 3);
        valid_seen = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 0, 0);
            if (replc_valid === 1'b1) valid_seen++;
        end
        vec_count++;
        if (valid_seen != 0) begin
            miscompares++;
            $display("[TB] FAIL single pulse: got %0d extra valid pulses, want 0", valid_seen);
        end
        runRequest("victim cleared over ref", 3);

        // Reset in the middle of a search: no pulse, counters and victim cleared.
        refs(0, 2); refs(1, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("mid scan busy", 1, 0, 3);
        applyStimulus(1, 0, 0, 0);
        checkOutput("mid scan reset", 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("after abort", 0, 0, 0);
        end
        refs(3, 1);
        runRequest("counters cleared by reset", 0);

        // Random traffic against the reference model.
        applyStimulus(1, 0, 0, 0);
        checkOutput("random reset", 0, 0, 0);
        for (int n = 0; n < 500; n++) begin
            r  = ($urandom_range(0, 63) == 0);
            rv = 1'($urandom_range(0, 1));
            rb = $urandom_range(0, 3);
            rq = ($urandom_range(0, 3) == 0);
`ifdef LFU_AGING_EN
            if (phase != 0 || rq) rv = 1'b0;
`endif
            applyStimulus(r, rv, rb, rq);
            checkOutput("random", (phase != 0), m_valid, m_victim);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
